// File: rtl/fifo_rd_ctrl_if.sv
// Read-side bus of the async FIFO: write-pointer crossing, RAM read port and
// the valid/ready output stream.
interface fifo_rd_ctrl_if #(
    parameter int Depth    = 8,
    parameter int Width    = 4,
    parameter int PtrWidth = $clog2(Depth)
);
    logic [PtrWidth:0]   i_wr_gptr;
    logic [PtrWidth:0]   o_rd_gptr;
    logic                o_rd_en;
    logic                o_rd_empty;
    logic [PtrWidth-1:0] o_rd_ptr;
    logic [Width-1:0]    i_rd_data;
    logic [Width-1:0]    o_data;
    logic                o_valid;
    logic                i_ready;
    logic [PtrWidth:0]   o_level;

    modport master (
        input  i_wr_gptr, i_rd_data, i_ready,
        output o_rd_gptr, o_rd_en, o_rd_empty, o_rd_ptr, o_data, o_valid, o_level
    );

    modport slave (
        output i_wr_gptr, i_rd_data, i_ready,
        input  o_rd_gptr, o_rd_en, o_rd_empty, o_rd_ptr, o_data, o_valid, o_level
    );
endinterface

// File: rtl/fifo_rd_ctrl.sv
// Async FIFO read controller: write-pointer sync, gray read pointer, empty flag
// and a 2-entry prefetch buffer giving one word per clock on valid/ready.
module fifo_rd_ctrl #(
    parameter int Depth      = 8,
    parameter int Width      = 4,
    parameter int PtrWidth   = $clog2(Depth),
    parameter int SyncStages = 2
) (
    input  logic           clk_rd,
    input  logic           rst_n,
    fifo_rd_ctrl_if.master bus
);
    localparam int PW = PtrWidth + 1;

    function automatic logic [PW-1:0] g2b(input logic [PW-1:0] g);
        logic [PW-1:0] b;
        b[PW-1] = g[PW-1];
        for (int i = PW - 2; i >= 0; i--) b[i] = b[i+1] ^ g[i];
        return b;
    endfunction

    // Asynchronous assert, synchronous release
    logic [1:0] r_rst_sync;
    logic       w_srst_n;

    always_ff @(posedge clk_rd or negedge rst_n) begin
        if (!rst_n) r_rst_sync <= '0;
        else        r_rst_sync <= {r_rst_sync[0], 1'b1};
    end
    assign w_srst_n = r_rst_sync[1];

    logic [SyncStages-1:0][PW-1:0] r_wsync;
    logic [PW-1:0]                 w_wq, w_wbin;

    always_ff @(posedge clk_rd or negedge w_srst_n) begin
        if (!w_srst_n) r_wsync <= '0;
        else           r_wsync <= {r_wsync[SyncStages-2:0], bus.i_wr_gptr};
    end
    assign w_wq   = r_wsync[SyncStages-1];
    assign w_wbin = g2b(w_wq);

    logic [PW-1:0]             r_rbin, r_rgray, r_level;
    logic                      r_empty;
    logic [1:0][Width-1:0]     r_buf;
    logic [1:0]                r_held;
    logic                      r_infl;
    logic                      w_pop, w_rd_en, w_tail;
    logic [2:0]                w_occ;
    logic [PW-1:0]             w_rbin_next, w_rgray_next;

    assign w_pop        = (r_held != 2'd0) & bus.i_ready;
    assign w_occ        = {1'b0, r_held} + {2'b0, r_infl};
    // Fetch only while the buffer plus the in-flight read leaves room after this pop
    assign w_rd_en      = w_srst_n & ~r_empty & (w_occ < (3'd2 + {2'b0, w_pop}));
    assign w_rbin_next  = r_rbin + {{PtrWidth{1'b0}}, w_rd_en};
    assign w_rgray_next = w_rbin_next ^ (w_rbin_next >> 1);
    assign w_tail       = (r_held == 2'd2) | ((r_held == 2'd1) & ~w_pop);

    always_ff @(posedge clk_rd or negedge w_srst_n) begin
        if (!w_srst_n) begin
            r_rbin  <= '0;
            r_rgray <= '0;
            r_empty <= 1'b1;
            r_level <= '0;
            r_buf   <= '0;
            r_held  <= '0;
            r_infl  <= 1'b0;
        end else begin
            r_rbin  <= w_rbin_next;
            r_rgray <= w_rgray_next;
            r_empty <= (w_rgray_next == w_wq);
            r_level <= w_wbin - w_rbin_next;
            r_infl  <= w_rd_en;
            r_held  <= r_held + {1'b0, r_infl} - {1'b0, w_pop};
            if (w_pop)  r_buf[0] <= r_buf[1];
            // Capture lands after the shift so a simultaneous pop sees the new tail
            if (r_infl) r_buf[w_tail] <= bus.i_rd_data;
        end
    end

    assign bus.o_rd_en    = w_rd_en;
    assign bus.o_rd_ptr   = r_rbin[PtrWidth-1:0];
    assign bus.o_rd_gptr  = r_rgray;
    assign bus.o_rd_empty = r_empty;
    assign bus.o_level    = r_level;
    assign bus.o_valid    = (r_held != 2'd0);
    assign bus.o_data     = r_buf[0];
endmodule

// File: tb/tb_fifo_rd_ctrl.sv
// Directed bench for fifo_rd_ctrl with a 1-cycle-latency RAM model.
module tb_fifo_rd_ctrl;
    logic clk_rd = 1'b0;
    logic rst_n  = 1'b0;
    always #5 clk_rd = ~clk_rd;

    fifo_rd_ctrl_if #(.Depth(8), .Width(4)) bus ();

    fifo_rd_ctrl #(.Depth(8), .Width(4), .SyncStages(2)) dut (
        .clk_rd (clk_rd),
        .rst_n  (rst_n),
        .bus    (bus)
    );

    logic [3:0] ram [8];
    logic [2:0] addr_q [$];
    logic [3:0] got_q  [$];
    int n_vec = 0;
    int n_err = 0;
    int first_c, last_c;

    always @(posedge clk_rd) begin
        if (bus.o_rd_en) begin
            bus.i_rd_data <= ram[bus.o_rd_ptr];
            addr_q.push_back(bus.o_rd_ptr);
        end
    end

    task automatic tick(input int n = 1);
        repeat (n) @(posedge clk_rd);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic collect(input int want, input int budget);
        first_c = -1;
        last_c  = -1;
        for (int c = 0; c < budget && got_q.size() < want; c++) begin
            if (bus.o_valid && bus.i_ready) begin
                got_q.push_back(bus.o_data);
                if (first_c < 0) first_c = c;
                last_c = c;
            end
            tick();
        end
    endtask

    initial begin
        bus.i_wr_gptr = '0;
        bus.i_ready   = 1'b0;
        bus.i_rd_data = '0;
        for (int k = 0; k < 8; k++) ram[k] = '0;

        // 1: reset
        tick(3);
        chk("rst_rd_en", bus.o_rd_en, 0);
        chk("rst_valid", bus.o_valid, 0);
        rst_n = 1'b1;
        for (int k = 0; k < 3; k++) begin
            chk("rel_empty", bus.o_rd_empty, 1);
            chk("rel_valid", bus.o_valid, 0);
            chk("rel_rd_en", bus.o_rd_en, 0);
            chk("rel_gptr",  bus.o_rd_gptr, 0);
            chk("rel_level", bus.o_level, 0);
            tick();
        end

        // 2: single word
        ram[0] = 4'hA;
        bus.i_ready = 1'b1;
        addr_q.delete();
        bus.i_wr_gptr = 4'b0001;
        tick(2);
        chk("t2_empty_e2", bus.o_rd_empty, 1);
        tick();
        chk("t2_empty_e3", bus.o_rd_empty, 0);
        chk("t2_rd_en",    bus.o_rd_en, 1);
        chk("t2_rd_ptr",   bus.o_rd_ptr, 0);
        tick();
        chk("t2_rd_en_off", bus.o_rd_en, 0);
        chk("t2_empty_back", bus.o_rd_empty, 1);
        chk("t2_gptr",     bus.o_rd_gptr, 4'b0001);
        chk("t2_valid_e4", bus.o_valid, 0);
        tick();
        chk("t2_valid",    bus.o_valid, 1);
        chk("t2_data",     bus.o_data, 4'hA);
        tick();
        chk("t2_valid_off", bus.o_valid, 0);
        tick(3);
        chk("t2_nreads",   addr_q.size(), 1);

        // reset back to pointer 0 for the burst
        rst_n = 1'b0;
        bus.i_wr_gptr = '0;
        tick(2);
        rst_n = 1'b1;
        tick(3);
        chk("r2_empty", bus.o_rd_empty, 1);
        chk("r2_gptr",  bus.o_rd_gptr, 0);

        // 3: full burst
        for (int k = 0; k < 8; k++) ram[k] = 4'(k);
        addr_q.delete();
        got_q.delete();
        bus.i_wr_gptr = 4'b1100;
        collect(8, 30);
        chk("t3_count", got_q.size(), 8);
        chk("t3_nogap", last_c - first_c, 7);
        for (int k = 0; k < 8; k++) chk("t3_data", got_q[k], k);
        chk("t3_nreads", addr_q.size(), 8);
        for (int k = 0; k < 8; k++) chk("t3_addr", addr_q[k], k);
        chk("t3_gptr",  bus.o_rd_gptr, 4'b1100);
        chk("t3_empty", bus.o_rd_empty, 1);
        chk("t3_valid", bus.o_valid, 0);

        // 4: backpressure
        bus.i_ready = 1'b0;
        addr_q.delete();
        got_q.delete();
        bus.i_wr_gptr = 4'b0000;
        tick(10);
        chk("t4_nreads", addr_q.size(), 2);
        chk("t4_level",  bus.o_level, 6);
        chk("t4_valid",  bus.o_valid, 1);
        chk("t4_data",   bus.o_data, 0);
        tick(3);
        chk("t4_data_hold", bus.o_data, 0);
        chk("t4_nreads_hold", addr_q.size(), 2);
        bus.i_ready = 1'b1;
        collect(8, 30);
        chk("t4_count", got_q.size(), 8);
        for (int k = 0; k < 8; k++) chk("t4_data_seq", got_q[k], k);
        chk("t4_nreads_all", addr_q.size(), 8);
        for (int k = 0; k < 8; k++) chk("t4_addr", addr_q[k], k);
        tick(2);
        chk("t4_empty", bus.o_rd_empty, 1);
        chk("t4_valid_end", bus.o_valid, 0);
        chk("t4_gptr", bus.o_rd_gptr, 0);

        // 5: wrap
        for (int k = 0; k < 4; k++) ram[k] = 4'(k + 1);
        addr_q.delete();
        got_q.delete();
        tick(2);
        chk("t5_empty_lap", bus.o_rd_empty, 1);
        bus.i_wr_gptr = 4'b0110;
        tick(2);
        chk("t5_empty_sync", bus.o_rd_empty, 1);
        collect(4, 20);
        tick(5);
        chk("t5_count", got_q.size(), 4);
        for (int k = 0; k < 4; k++) chk("t5_data", got_q[k], k + 1);
        chk("t5_nreads", addr_q.size(), 4);
        for (int k = 0; k < 4; k++) chk("t5_addr", addr_q[k], k);
        chk("t5_valid", bus.o_valid, 0);
        chk("t5_empty", bus.o_rd_empty, 1);
        chk("t5_gptr",  bus.o_rd_gptr, 4'b0110);

        // 6: reset mid-burst
        got_q.delete();
        bus.i_wr_gptr = 4'b1010;
        collect(3, 30);
        chk("t6_count", got_q.size(), 3);
        for (int k = 0; k < 3; k++) chk("t6_data", got_q[k], k + 4);
        rst_n = 1'b0;
        #1;
        chk("t6_valid_async", bus.o_valid, 0);
        chk("t6_rd_en_rst",   bus.o_rd_en, 0);
        chk("t6_empty_rst",   bus.o_rd_empty, 1);
        bus.i_wr_gptr = '0;
        tick(2);
        rst_n = 1'b1;
        tick(3);
        chk("t6_empty_rel", bus.o_rd_empty, 1);
        chk("t6_ptr_rel",   bus.o_rd_ptr, 0);
        chk("t6_gptr_rel",  bus.o_rd_gptr, 0);
        chk("t6_valid_rel", bus.o_valid, 0);
        chk("t6_level_rel", bus.o_level, 0);
        addr_q.delete();
        got_q.delete();
        bus.i_wr_gptr = 4'b0001;
        collect(1, 20);
        chk("t6_post_count", got_q.size(), 1);
        chk("t6_post_data",  got_q[0], 1);
        chk("t6_post_addr",  addr_q[0], 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
